nios2_oci_trace_packer: RTL and testbench
=========================================

Name: nios2_oci_trace_packer

Overview:
- Parametrised successor to the OCI test-bench trace sink.
- Packs a stream of narrow trace slots into DCT words (dct_buffer + dct_count) and hands them out on a valid/ready handshake.
- Supports end-of-test flush of a partial word, raises a sticky ended flag, and reports overflow and word count.
- Sits between the OCI trace source and the simulation/debug capture logic.

Parameters:
- SLOT_W, 3, bits per trace slot
- SLOTS, 10, slots per DCT word; dct_buffer width = SLOT_W*SLOTS (default 30)
- COUNT_W, 4, width of dct_count; must satisfy 2**COUNT_W > SLOTS
- WORDS_W, 16, width of the words_sent counter

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- tr_valid  in  1  trace slot valid
- tr_slot  in  SLOT_W  trace slot data
- test_ending  in  1  request end-of-test flush
- dct_ready  in  1  consumer accepts dct word
- dct_valid  out  1  dct word available
- dct_buffer  out  SLOT_W*SLOTS  packed word; slot k at bits [k*SLOT_W +: SLOT_W], k=0 first received
- dct_count  out  COUNT_W  number of valid slots in dct_buffer (1..SLOTS)
- test_has_ended  out  1  flush complete, held until reset
- overflow  out  1  sticky: at least one slot dropped
- words_sent  out  WORDS_W  count of completed handshakes, wraps modulo 2**WORDS_W

Behaviour:
- Reset: all outputs 0; accumulator, acc_cnt and FSM cleared; partial data discarded. Applies mid-operation, including while dct_valid is high.
- Internal state: accumulator acc and acc_cnt (0..SLOTS), plus a one-entry output register driving dct_buffer, dct_count and dct_valid.
- out_free = !dct_valid || dct_ready.
- Handshake:
  - A word transfers on any edge where dct_valid && dct_ready; words_sent increments on that edge.
  - While dct_valid && !dct_ready, dct_buffer and dct_count hold stable.
- FSM states: RUN (reset state), FLUSH, DRAIN, ENDED.
- RUN, accept:
  - tr_valid with acc_cnt<SLOTS: slot written at index acc_cnt; acc_cnt increments.
- RUN, acc_cnt==SLOTS && out_free:
  - acc loads the output register with dct_count=SLOTS; dct_valid=1 next cycle.
  - acc_cnt becomes 0, or 1 if tr_valid that same cycle (incoming slot goes to index 0).
  - Latency: the slot completing a word is accepted at edge N; dct_valid is high after edge N+1.
- RUN, acc_cnt==SLOTS && !out_free && tr_valid: slot dropped, overflow set (sticky until reset), acc unchanged.
- RUN with test_ending=1: go to FLUSH next edge. tr_valid on that cycle is still accepted under the RUN rules; tr_valid is ignored in every later state.
- FLUSH:
  - acc_cnt==0: go to DRAIN.
  - Otherwise wait for out_free, then load the output with dct_count=acc_cnt, unused upper slots zero. acc_cnt becomes 0; go to DRAIN.
- DRAIN: when dct_valid==0, or a handshake occurs this cycle, go to ENDED.
- ENDED: test_has_ended=1. All inputs except reset are ignored; dct_valid stays 0.
- test_ending while not in RUN: no effect.
- Width rules:
  - dct_count is zero-extended from acc_cnt.
  - words_sent wraps from 2**WORDS_W-1 to 0 with no flag.

Test Plan:
- Full word: reset; 10 consecutive slots 1,2,...,7,0,1,2 with dct_ready=1 -> dct_valid high for 1 cycle, 2 cycles after the 10th slot. dct_buffer = slots packed LSB-first, dct_count=10, words_sent=1.
- Backpressure/overflow:
  - Setup: dct_ready=0; send 25 slots.
  - First word is held stable with dct_valid=1; acc fills to 10.
  - The 5 extra slots are dropped and overflow=1.
  - Raise dct_ready -> 2 words emitted, words_sent=2, overflow stays 1.
- Partial flush: 4 slots 5,6,7,1, then test_ending -> one word with dct_count=4, dct_buffer[11:0]=1,7,6,5 (slot 3 in bits 11:9), upper 18 bits 0. test_has_ended=1 after the handshake.
- Empty flush: test_ending with acc_cnt=0 and no word pending -> test_has_ended=1 within 3 cycles, no dct_valid pulse.
- Simultaneous: 10th slot and test_ending in the same cycle -> full word with dct_count=10, then no partial word. tr_valid after that cycle is ignored, words_sent=1, ended.
- Reset mid-operation: assert reset while dct_valid=1 with 3 slots buffered -> next cycle all outputs 0. A subsequent 10-slot sequence yields a correct fresh word.

Source files
------------

// File: rtl/nios2_oci_trace_packer.sv
// Trace slot packer: gathers narrow trace slots into DCT words and hands
// them to the capture logic over a valid/ready handshake. Handles the
// end-of-test flush of a partial word and keeps overflow/word statistics.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal packing; full words move to the output register
// ST_FLUSH | end of test requested; push out any partial word
// ST_DRAIN | wait for the last pending word to be taken
// ST_ENDED | flush complete; everything but reset is ignored
module nios2_oci_trace_packer #(
   parameter int SLOT_W  = 3,
   parameter int SLOTS   = 10,
   parameter int COUNT_W = 4,
   parameter int WORDS_W = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      tr_valid,
   input  logic [SLOT_W-1:0]         tr_slot,
   input  logic                      test_ending,
   input  logic                      dct_ready,
   output logic                      dct_valid,
   output logic [SLOT_W*SLOTS-1:0]   dct_buffer,
   output logic [COUNT_W-1:0]        dct_count,
   output logic                      test_has_ended,
   output logic                      overflow,
   output logic [WORDS_W-1:0]        words_sent
);

   localparam int                 W    = SLOT_W * SLOTS;
   localparam logic [COUNT_W-1:0] FULL = COUNT_W'(SLOTS);

   typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_DRAIN, ST_ENDED} state_t;

   state_t               state_q, state_d;
   logic [W-1:0]         acc_q, acc_d;
   logic [COUNT_W-1:0]   acc_cnt_q, acc_cnt_d;
   logic [W-1:0]         out_buf_q, out_buf_d;
   logic [COUNT_W-1:0]   out_cnt_q, out_cnt_d;
   logic                 out_valid_q, out_valid_d;
   logic                 ovf_q, ovf_d;
   logic [WORDS_W-1:0]   words_q, words_d;

   logic                 handshake;
   logic                 out_free;

   assign handshake = out_valid_q && dct_ready;
   assign out_free  = !out_valid_q || dct_ready;

   // Register update with synchronous reset; partial data is discarded.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_RUN;
         acc_q       <= '0;
         acc_cnt_q   <= '0;
         out_buf_q   <= '0;
         out_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         words_q     <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         acc_cnt_q   <= acc_cnt_d;
         out_buf_q   <= out_buf_d;
         out_cnt_q   <= out_cnt_d;
         out_valid_q <= out_valid_d;
         ovf_q       <= ovf_d;
         words_q     <= words_d;
      end
   end

   // Next-state logic: packing, word hand-off, flush sequencing.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      acc_cnt_d   = acc_cnt_q;
      out_buf_d   = out_buf_q;
      out_cnt_d   = out_cnt_q;
      out_valid_d = out_valid_q;
      ovf_d       = ovf_q;
      words_d     = words_q;

      if (handshake) begin
         out_valid_d = 1'b0;
         words_d     = words_q + WORDS_W'(1);
      end

      unique case (state_q)
         ST_RUN: begin
            if (acc_cnt_q == FULL) begin
               if (out_free) begin
                  // Accumulator is cleared on hand-off so a later partial
                  // flush always carries zeros in its unused slots.
                  out_buf_d   = acc_q;
                  out_cnt_d   = FULL;
                  out_valid_d = 1'b1;
                  acc_d       = '0;
                  acc_cnt_d   = '0;
                  if (tr_valid) begin
                     acc_d[SLOT_W-1:0] = tr_slot;
                     acc_cnt_d         = COUNT_W'(1);
                  end
               end else if (tr_valid) begin
                  ovf_d = 1'b1;
               end
            end else if (tr_valid) begin
               for (int k = 0; k < SLOTS; k++) begin
                  if (acc_cnt_q == COUNT_W'(k)) begin
                     acc_d[k*SLOT_W +: SLOT_W] = tr_slot;
                  end
               end
               acc_cnt_d = acc_cnt_q + COUNT_W'(1);
            end
            if (test_ending) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (acc_cnt_q == '0) begin
               state_d = ST_DRAIN;
            end else if (out_free) begin
               out_buf_d   = acc_q;
               out_cnt_d   = acc_cnt_q;
               out_valid_d = 1'b1;
               acc_d       = '0;
               acc_cnt_d   = '0;
               state_d     = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!out_valid_q || handshake) begin
               state_d = ST_ENDED;
            end
         end
         ST_ENDED: begin
            state_d = ST_ENDED;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   assign dct_valid      = out_valid_q;
   assign dct_buffer     = out_buf_q;
   assign dct_count      = out_cnt_q;
   assign test_has_ended = (state_q == ST_ENDED);
   assign overflow       = ovf_q;
   assign words_sent     = words_q;

endmodule

// File: tb/tb_nios2_oci_trace_packer.sv
// Bench for the trace packer: a queue-based model of the packing rules is
// stepped on every clock and compared against the DUT on every falling
// edge; directed scenarios add hand-computed literal expectations.
module tb_nios2_oci_trace_packer;

   localparam int SLOT_W  = 3;
   localparam int SLOTS   = 10;
   localparam int COUNT_W = 4;
   localparam int WORDS_W = 16;
   localparam int W       = SLOT_W * SLOTS;

   logic                clk = 1'b0;
   logic                reset;
   logic                tr_valid;
   logic [SLOT_W-1:0]   tr_slot;
   logic                test_ending;
   logic                dct_ready;
   logic                dct_valid;
   logic [W-1:0]        dct_buffer;
   logic [COUNT_W-1:0]  dct_count;
   logic                test_has_ended;
   logic                overflow;
   logic [WORDS_W-1:0]  words_sent;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   nios2_oci_trace_packer #(
      .SLOT_W(SLOT_W), .SLOTS(SLOTS), .COUNT_W(COUNT_W), .WORDS_W(WORDS_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .tr_valid       (tr_valid),
      .tr_slot        (tr_slot),
      .test_ending    (test_ending),
      .dct_ready      (dct_ready),
      .dct_valid      (dct_valid),
      .dct_buffer     (dct_buffer),
      .dct_count      (dct_count),
      .test_has_ended (test_has_ended),
      .overflow       (overflow),
      .words_sent     (words_sent)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [SLOT_W-1:0]   mq[$];
   bit                  m_valid = 1'b0;
   logic [W-1:0]        m_buf   = '0;
   int                  m_cnt   = 0;
   bit                  m_ovf   = 1'b0;
   logic [WORDS_W-1:0]  m_words = '0;
   int                  m_phase = 0;   // 0 run, 1 flush, 2 drain, 3 ended

   function automatic logic [W-1:0] pack(input logic [SLOT_W-1:0] q[$]);
      logic [W-1:0] r = '0;
      foreach (q[k]) r[k*SLOT_W +: SLOT_W] = q[k];
      return r;
   endfunction

   // Model step: one spec-level transition per rising edge.
   always @(posedge clk) begin
      bit v_old, hs, free;
      if (reset) begin
         mq.delete();
         m_valid = 1'b0; m_buf = '0; m_cnt = 0; m_ovf = 1'b0;
         m_words = '0; m_phase = 0;
      end else begin
         v_old = m_valid;
         hs    = m_valid && dct_ready;
         free  = !m_valid || dct_ready;
         if (hs) begin
            m_words = m_words + 1'b1;
            m_valid = 1'b0;
         end
         case (m_phase)
            0: begin
               if (mq.size() == SLOTS) begin
                  if (free) begin
                     m_buf = pack(mq); m_cnt = SLOTS; m_valid = 1'b1;
                     mq.delete();
                     if (tr_valid) mq.push_back(tr_slot);
                  end else if (tr_valid) begin
                     m_ovf = 1'b1;
                  end
               end else if (tr_valid) begin
                  mq.push_back(tr_slot);
               end
               if (test_ending) m_phase = 1;
            end
            1: begin
               if (mq.size() == 0) m_phase = 2;
               else if (free) begin
                  m_buf = pack(mq); m_cnt = mq.size(); m_valid = 1'b1;
                  mq.delete();
                  m_phase = 2;
               end
            end
            2: if (!v_old || hs) m_phase = 3;
            default: ;
         endcase
      end
   end

   // Compare DUT against the model away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("dct_valid", 64'(dct_valid), 64'(m_valid));
         if (m_valid) begin
            chk("dct_buffer", 64'(dct_buffer), 64'(m_buf));
            chk("dct_count", 64'(dct_count), 64'(m_cnt));
         end
         chk("overflow", 64'(overflow), 64'(m_ovf));
         chk("words_sent", 64'(words_sent), 64'(m_words));
         chk("test_has_ended", 64'(test_has_ended), 64'(m_phase == 3));
      end
   end

   // ---------------- stimulus ----------------
   int seq1[SLOTS] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
   localparam logic [W-1:0] WORD_SEQ1 = 30'o2107654321;
   localparam logic [W-1:0] WORD_PART = 30'o1765;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1; tr_valid = 1'b0; test_ending = 1'b0;
      step();
      reset = 1'b0;
   endtask

   task automatic send(input int v);
      tr_valid = 1'b1;
      tr_slot  = SLOT_W'(v);
      step();
   endtask

   task automatic wait_valid(input string name, input int budget);
      int n = 0;
      while (!dct_valid && n < budget) begin step(); n++; end
      if (!dct_valid) chk({name, "_timeout"}, 64'(1), 64'(0));
   endtask

   task automatic wait_ended(input string name, input int budget);
      int n = 0;
      while (!test_has_ended && n < budget) begin step(); n++; end
      chk({name, "_ended"}, 64'(test_has_ended), 64'(1));
   endtask

   initial begin
      reset = 1'b1; tr_valid = 1'b0; tr_slot = '0; test_ending = 1'b0; dct_ready = 1'b0;
      step(); step();
      chk_en = 1'b1;
      chk("rst_valid", 64'(dct_valid), 64'(0));
      chk("rst_count", 64'(dct_count), 64'(0));
      chk("rst_words", 64'(words_sent), 64'(0));
      chk("rst_ended", 64'(test_has_ended), 64'(0));

      // Full word with ready held high.
      reset = 1'b0; dct_ready = 1'b1;
      for (int i = 0; i < SLOTS; i++) send(seq1[i]);
      tr_valid = 1'b0;
      chk("full_lat1", 64'(dct_valid), 64'(0));
      step();
      chk("full_lat2", 64'(dct_valid), 64'(1));
      chk("full_buf", 64'(dct_buffer), 64'(WORD_SEQ1));
      chk("full_cnt", 64'(dct_count), 64'(10));
      step();
      chk("full_pulse", 64'(dct_valid), 64'(0));
      chk("full_words", 64'(words_sent), 64'(1));

      // Backpressure and overflow.
      do_reset();
      dct_ready = 1'b0;
      for (int i = 0; i < 25; i++) send(i % 8);
      tr_valid = 1'b0;
      step(); step();
      chk("bp_valid", 64'(dct_valid), 64'(1));
      chk("bp_buf", 64'(dct_buffer), 64'(30'o1076543210));
      chk("bp_ovf", 64'(overflow), 64'(1));
      dct_ready = 1'b1;
      for (int n = 0; n < 10 && words_sent != 16'd2; n++) step();
      step();
      chk("bp_words", 64'(words_sent), 64'(2));
      chk("bp_ovf_sticky", 64'(overflow), 64'(1));
      chk("bp_idle", 64'(dct_valid), 64'(0));

      // Partial flush of four slots.
      do_reset();
      dct_ready = 1'b1;
      send(5); send(6); send(7); send(1);
      tr_valid = 1'b0; test_ending = 1'b1;
      step();
      test_ending = 1'b0;
      wait_valid("part", 5);
      chk("part_cnt", 64'(dct_count), 64'(4));
      chk("part_buf", 64'(dct_buffer), 64'(WORD_PART));
      wait_ended("part", 5);
      chk("part_words", 64'(words_sent), 64'(1));

      // Empty flush: no word may appear.
      do_reset();
      test_ending = 1'b1;
      step();
      test_ending = 1'b0;
      for (int n = 0; n < 3 && !test_has_ended; n++) begin
         chk("empty_novalid", 64'(dct_valid), 64'(0));
         step();
      end
      chk("empty_ended", 64'(test_has_ended), 64'(1));
      chk("empty_words", 64'(words_sent), 64'(0));

      // Tenth slot together with test_ending.
      do_reset();
      for (int i = 0; i < SLOTS - 1; i++) send(seq1[i]);
      test_ending = 1'b1;
      send(seq1[SLOTS-1]);
      test_ending = 1'b0;
      for (int i = 0; i < 6; i++) send(i + 1);
      tr_valid = 1'b0;
      wait_ended("simul", 8);
      step(); step();
      chk("simul_words", 64'(words_sent), 64'(1));
      chk("simul_idle", 64'(dct_valid), 64'(0));

      // Reset while a word is pending and three slots are buffered.
      do_reset();
      dct_ready = 1'b0;
      for (int i = 0; i < 13; i++) send(i % 8);
      tr_valid = 1'b0;
      chk("mid_pending", 64'(dct_valid), 64'(1));
      reset = 1'b1;
      step();
      chk("mid_valid", 64'(dct_valid), 64'(0));
      chk("mid_buf", 64'(dct_buffer), 64'(0));
      chk("mid_cnt", 64'(dct_count), 64'(0));
      chk("mid_ovf", 64'(overflow), 64'(0));
      reset = 1'b0; dct_ready = 1'b1;
      for (int i = 0; i < SLOTS; i++) send(seq1[i]);
      tr_valid = 1'b0;
      wait_valid("fresh", 4);
      chk("fresh_buf", 64'(dct_buffer), 64'(WORD_SEQ1));
      chk("fresh_cnt", 64'(dct_count), 64'(10));
      step(); step();

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
